// File: rtl/rk_pkg.sv
// Shared definitions for the RK loop sequencer: default word width and FSM state encoding.
// Imported by the interface, the comparator and the top.
package rk_pkg;

    localparam int RK_N = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_FIN   = 3'd4
    } rk_state_t;

endpackage

// File: rtl/rk_loop_ctrl_if.sv
// Host + datapath handshake bundle for rk_loop_ctrl; master = host/datapath side, slave = sequencer.
// No storage; step_start/step_done form a one-outstanding-step request/response pair.
interface rk_loop_ctrl_if
    import rk_pkg::*;
#(
    parameter int N = RK_N
);
    logic         start;
    logic         abort;
    logic [N-1:0] n_steps;
    logic [N-1:0] t0;
    logic [N-1:0] h;
    logic         step_done;
    logic         step_start;
    logic [N-1:0] step_idx;
    logic [N-1:0] t_cur;
    logic         busy;
    logic         done;

    modport master (
        output start, abort, n_steps, t0, h, step_done,
        input  step_start, step_idx, t_cur, busy, done
    );

    modport slave (
        input  start, abort, n_steps, t0, h, step_done,
        output step_start, step_idx, t_cur, busy, done
    );
endinterface

// File: rtl/rk_loop_ctrl_cmp.sv
// N-bit unsigned magnitude comparator, purely combinational (zero latency).
// Exactly one of lt/eq/gt is high for any pair of operands.
module rk_loop_ctrl_cmp
    import rk_pkg::*;
#(
    parameter int N = RK_N
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         lt,
    output logic         eq,
    output logic         gt
);

    assign lt = (a <  b);
    assign eq = (a == b);
    assign gt = (a >  b);

endmodule

// File: rtl/rk_loop_ctrl.sv
// Sequences n_steps RK steps: issues step_start, waits for step_done, advances step_idx/t_cur, pulses done.
// start -> step_start next cycle; step_done -> next step_start/done two cycles later; datapath paces via step_done.
module rk_loop_ctrl
    import rk_pkg::*;
#(
    parameter int N = RK_N
) (
    input  logic         clk,
    input  logic         rst_n,
    rk_loop_ctrl_if.slave bus
);

    rk_state_t    state;
    rk_state_t    state_nxt;

    logic [N-1:0] n_lat;
    logic [N-1:0] h_lat;
    logic [N-1:0] idx_q;
    logic [N-1:0] t_q;

    logic         cmp_lt;
    logic         cmp_eq;
    logic         cmp_gt;

    logic         accept;
    logic         advance;

    assign accept  = (state == S_IDLE) && bus.start && !bus.abort;
    assign advance = (state == S_WAIT) && bus.step_done && !bus.abort;

    rk_loop_ctrl_cmp #(
        .N (N)
    ) u_cmp (
        .a  (idx_q),
        .b  (n_lat),
        .lt (cmp_lt),
        .eq (cmp_eq),
        .gt (cmp_gt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus.abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state_nxt = (bus.n_steps == '0) ? S_FIN : S_ISSUE;
                    end
                end
                S_ISSUE: state_nxt = S_WAIT;
                S_WAIT: begin
                    if (bus.step_done) begin
                        state_nxt = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (cmp_lt) begin
                        state_nxt = S_ISSUE;
                    end else if (cmp_eq || cmp_gt) begin
                        state_nxt = S_FIN;
                    end
                end
                S_FIN:   state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Run parameters are captured only on an accepted start, so host-side changes mid-run are invisible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_lat <= '0;
            h_lat <= '0;
            idx_q <= '0;
            t_q   <= '0;
        end else if (accept) begin
            n_lat <= bus.n_steps;
            h_lat <= bus.h;
            idx_q <= '0;
            t_q   <= bus.t0;
        end else if (advance) begin
            idx_q <= idx_q + N'(1);
            t_q   <= t_q + h_lat;
        end
    end

    assign bus.step_start = (state == S_ISSUE);
    assign bus.done       = (state == S_FIN);
    assign bus.busy       = (state != S_IDLE);
    assign bus.step_idx   = idx_q;
    assign bus.t_cur      = t_q;

endmodule
